// File: rtl/rram_readout_buffer.sv
// RRAM readout buffer: captures ADC/CSA results from the array controller into a
// tagged result FIFO and exposes it through a small Wishbone register window.
module rram_readout_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ENABLE_ADC,
    input  logic [1:0]  CLK_EN_ADC,
    input  logic        SAEN_CSA,
    input  logic [15:0] ADC_OUT0,
    input  logic [15:0] ADC_OUT1,
    input  logic [15:0] ADC_OUT2,
    input  logic [15:0] CSA,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Capture edge detection
    logic adc_cond, adc_prev, adc_evt;
    logic csa_prev, csa_evt;

    // ADC decode
    logic [31:0] adc_word;
    logic [5:0]  adc_sum;
    logic        adc_bubble;

    // FIFO state
    logic [32:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [5:0]    count;
    logic          full, empty;
    logic [32:0]   head;
    logic          head_tag;

    // Control / status
    logic       irq_en;
    logic       overflow;
    logic       bubble_err;
    logic [5:0] last_sum;

    // Wishbone decode
    logic [31:0] offset;
    logic        in_win, req, wr_ctrl, flush, clr_err, pop;
    logic [31:0] rd_data;
    logic [31:0] status;

    // Push path
    logic        push_req, do_push, ovf_set;
    logic [32:0] push_data;

    logic unused_dat;
    assign unused_dat = ^wbs_dat_i[31:3];

    assign adc_cond = ENABLE_ADC & (CLK_EN_ADC == 2'b11);
    assign adc_evt  = adc_cond & ~adc_prev;
    assign csa_evt  = SAEN_CSA & ~csa_prev;

    // Column code is the popcount even for bubbled patterns; the bubble is only flagged.
    always_comb begin
        adc_word   = '0;
        adc_sum    = '0;
        adc_bubble = 1'b0;
        for (int unsigned c = 0; c < 16; c++) begin
            adc_word[2*c +: 2] = {1'b0, ADC_OUT0[c]} + {1'b0, ADC_OUT1[c]} + {1'b0, ADC_OUT2[c]};
            adc_sum            = adc_sum + {4'b0, adc_word[2*c +: 2]};
            adc_bubble         = adc_bubble | (ADC_OUT2[c] & ~ADC_OUT1[c])
                                            | (ADC_OUT1[c] & ~ADC_OUT0[c]);
        end
    end

    assign full     = (count == 6'(DEPTH));
    assign empty    = (count == 6'd0);
    assign head     = mem[rd_ptr];
    assign head_tag = ~empty & head[32];

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window too.
    assign offset  = wbs_adr_i - BASE_ADDR;
    assign in_win  = (offset < 32'd16);
    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & in_win;
    assign wr_ctrl = req & wbs_we_i & (offset[3:0] == 4'h8);
    assign flush   = wr_ctrl & wbs_dat_i[1];
    assign clr_err = wr_ctrl & wbs_dat_i[2];
    assign pop     = req & ~wbs_we_i & (offset[3:0] == 4'h0) & ~empty;

    assign status = {16'h0, 2'b00, count, 3'b000, head_tag, bubble_err, overflow, full, empty};

    always_comb begin
        rd_data = '0;
        if (!wbs_we_i) begin
            case (offset[3:0])
                4'h0:    rd_data = empty ? 32'h0 : head[31:0];
                4'h4:    rd_data = status;
                4'h8:    rd_data = {31'h0, irq_en};
                4'hC:    rd_data = {26'h0, last_sum};
                default: rd_data = '0;
            endcase
        end
    end

    // ADC wins a same-cycle collision; the CSA result is lost and flagged.
    always_comb begin
        push_req  = adc_evt | csa_evt;
        push_data = adc_evt ? {1'b1, adc_word} : {1'b0, 16'h0, CSA};
        do_push   = push_req & ~flush & (~full | pop);
        ovf_set   = ~flush & ((adc_evt & csa_evt) | (push_req & full & ~pop));
    end

    assign irq = irq_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            adc_prev   <= 1'b0;
            csa_prev   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            bubble_err <= 1'b0;
            irq_en     <= 1'b0;
            last_sum   <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
        end else begin
            adc_prev  <= adc_cond;
            csa_prev  <= SAEN_CSA;
            wbs_ack_o <= req;
            if (req) begin
                wbs_dat_o <= rd_data;
            end
            if (wr_ctrl) begin
                irq_en <= wbs_dat_i[0];
            end

            // Clear first so an error arriving in the same cycle is not lost.
            if (clr_err) begin
                overflow   <= 1'b0;
                bubble_err <= 1'b0;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end
            if (adc_evt) begin
                last_sum <= adc_sum;
                if (adc_bubble) begin
                    bubble_err <= 1'b1;
                end
            end

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + {5'b0, do_push} - {5'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
